pipe_skid_reg: RTL and testbench

- Two-entry valid/ready register slice (skid buffer). It breaks both the forward path (valid/data) and the backward path (ready) with flops.
- Placed between pipeline stages that are built from the team's reset-flop primitive, wherever a stage needs back-pressure without a combinational ready path.
- Upstream sees a fully registered in_ready. Downstream sees a fully registered out_valid/out_data.
- Sustains one transfer per cycle when the consumer is always ready.

---
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry valid/ready skid buffer with fully registered in_ready/out_valid/out_data
// Optional stall counter enabled by defining PIPE_SKID_REG_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int             W     = 32,
  parameter logic [W-1:0]   INIT  = '0,
  parameter int             CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           out_valid_q;
  logic           in_ready_q;
  logic           push;
  logic           pop;

  if (W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_skid_reg: W and CNT_W must be at least 1");
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Flag flops take their value from the next state so they stay in step with it.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= EMPTY;
      main_q      <= INIT;
      skid_q      <= INIT;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg against a queue-based reference model
module tb_pipe_skid_reg;

  localparam int           W     = 32;
  localparam logic [W-1:0] INIT  = 32'hDEAD_BEEF;
  localparam int           CNT_W = 4;
  localparam int           CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  pipe_skid_reg #(.W(W), .INIT(INIT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           ncmp  = 0;
  int           nfail = 0;
  string        phase = "init";
  logic [W-1:0] q[$];
  logic [W-1:0] last_head = INIT;
  int           scnt = 0;
  logic [W-1:0] dut_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the transfer rules, compare.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic rn);
    int   n;
    logic push_m;
    logic pop_m;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    arst_n    = rn;
    if (rn && out_valid && out_ready) dut_log.push_back(out_data);
    n      = q.size();
    push_m = v && (n < 2);
    pop_m  = (n > 0) && r;
    @(posedge clk);
    #1;
    if (!rn) begin
      q.delete();
      last_head = INIT;
      scnt      = 0;
    end else begin
      if (n > 0 && !r && scnt < CMAX) scnt++;
      if (pop_m) last_head = q.pop_front();
      if (push_m) q.push_back(d);
    end
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_data", 64'(out_data), 64'((q.size() > 0) ? q[0] : last_head));
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(scnt));
`endif
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    arst_n    = 1'b0;

    phase = "reset_idle";
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_data", 64'(out_data), 64'(INIT));
    for (int i = 0; i < 3; i++) step(1'b0, W'($urandom), 1'b0, 1'b1);
    chk("idle_ready", 64'(in_ready), 64'd1);

    phase = "stream";
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b1);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    step(1'b0, '0, 1'b1, 1'b1);

    phase = "fill";
    dut_log.delete();
    step(1'b1, W'(32'hA), 1'b0, 1'b1);
    step(1'b1, W'(32'hB), 1'b0, 1'b1);
    chk("full_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(32'hC), 1'b0, 1'b1);
      chk("held_data", 64'(out_data), 64'hA);
    end

    phase = "drain";
    step(1'b0, '0, 1'b1, 1'b1);
    chk("drain_data", 64'(out_data), 64'hB);
    chk("drain_ready", 64'(in_ready), 64'd1);
    step(1'b1, W'(32'hC), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("order_len", 64'(dut_log.size()), 64'd3);
    if (dut_log.size() == 3) begin
      chk("order0", 64'(dut_log[0]), 64'hA);
      chk("order1", 64'(dut_log[1]), 64'hB);
      chk("order2", 64'(dut_log[2]), 64'hC);
    end

    phase = "random";
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)), 1'b1);

    phase = "mid_reset";
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, W'(32'h55), 1'b0, 1'b1);
    step(1'b1, W'(32'h66), 1'b0, 1'b1);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_data2", 64'(out_data), 64'(INIT));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      chk("no_ghost", 64'(out_valid), 64'd0);
    end

`ifdef PIPE_SKID_REG_STALL_CNT_EN
    phase = "stall_sat";
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, W'(32'h77), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("stall_sat", 64'(stall_cnt), 64'(CMAX));
    step(1'b0, '0, 1'b0, 1'b1);
    chk("stall_hold", 64'(stall_cnt), 64'(CMAX));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
